// File: rtl/cpu_defs.sv
// Definitions shared by the fetch unit and the ControlUnit:
// opcodes, instruction geometry and fetch FSM encoding.
package cpu_defs;

    localparam int DATA_W      = 8;
    localparam int INSTR_BYTES = 3;
    localparam int CW_W        = DATA_W * INSTR_BYTES;

    localparam int OPC_HI = 23;
    localparam int OPC_LO = 16;
    localparam int OP1_HI = 15;
    localparam int OP1_LO = 8;
    localparam int OP2_HI = 7;
    localparam int OP2_LO = 0;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_STORE = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_JMP   = 8'h04;
    localparam logic [7:0] OP_CALL  = 8'h05;
    localparam logic [7:0] OP_RET   = 8'h06;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FULL,
        ST_FLUSH
    } fetch_state_t;

endpackage

// File: rtl/fetch_mem_if.sv
// Byte-wide read handshake: walks MAR+0..N-1, reports each
// accepted byte and drains a request abandoned by a jump.
module fetch_mem_if
    import cpu_defs::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int INSTR_BYTES = 3,
    localparam int CNT_W       = $clog2(INSTR_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_mar,
    input  logic              i_mem_ack,
    output logic              o_mem_req,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic              o_byte_vld,
    output logic [CNT_W-1:0]  o_slot,
    output logic              o_last
);

    logic             r_req;
    logic             r_drop;
    logic [CNT_W-1:0] r_cnt;
    logic             w_ack;
    logic             w_last_slot;

    assign w_ack       = r_req & i_mem_ack;
    assign w_last_slot = (r_cnt == CNT_W'(INSTR_BYTES - 1));
    assign o_byte_vld  = w_ack & ~r_drop & ~i_abort;
    assign o_last      = o_byte_vld & w_last_slot;
    assign o_slot      = r_cnt;
    assign o_mem_req   = r_req;
    assign o_mem_addr  = i_mar + DATA_W'(r_cnt);

    // An aborted request stays up until its ack arrives; the data is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_req  <= 1'b0;
            r_drop <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_req  <= 1'b1;
            r_drop <= 1'b0;
            r_cnt  <= '0;
        end else if (w_ack) begin
            r_drop <= 1'b0;
            if (r_drop || i_abort || w_last_slot)
                r_req <= 1'b0;
            else
                r_cnt <= r_cnt + 1'b1;
        end else if (i_abort && r_req) begin
            r_drop <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, MAR, 3-byte assembly buffer and IR,
// driven by the ControlUnit fetch strobes.
module instr_fetch_unit
    import cpu_defs::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                INSTR_BYTES = 3,
    parameter logic [DATA_W-1:0] RESET_PC    = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             PC_load,
    input  logic                          PC_en,
    input  logic                          PC_inc,
    input  logic                          MAR_load,
    input  logic                          IR_load,
    output logic [DATA_W-1:0]             mem_addr,
    output logic                          mem_req,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [DATA_W*INSTR_BYTES-1:0] command_word,
    output logic                          ReadyRegFlag,
    output logic [DATA_W-1:0]             pc_out
);

    localparam int W_CW  = DATA_W * INSTR_BYTES;
    localparam int CNT_W = $clog2(INSTR_BYTES);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_mar;
    logic [W_CW-1:0]   r_buf;
    logic [W_CW-1:0]   r_cw;
    logic              r_rdy;
    logic              r_inc_done;
    logic              w_start;
    logic              w_commit;
    logic              w_byte_vld;
    logic              w_last;
    logic [CNT_W-1:0]  w_slot;
    logic              w_mem_req;

    fetch_mem_if #(
        .DATA_W      (DATA_W),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_mem_if (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_abort    (PC_en),
        .i_mar      (r_mar),
        .i_mem_ack  (mem_ack),
        .o_mem_req  (w_mem_req),
        .o_mem_addr (mem_addr),
        .o_byte_vld (w_byte_vld),
        .o_slot     (w_slot),
        .o_last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (PC_en) begin
            w_state_nxt = (w_mem_req && !mem_ack) ? ST_FLUSH : ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:  if (MAR_load) w_state_nxt = ST_FETCH;
                ST_FETCH: if (w_last)   w_state_nxt = ST_FULL;
                ST_FULL:  if (IR_load)  w_state_nxt = ST_IDLE;
                ST_FLUSH: if (mem_ack)  w_state_nxt = ST_IDLE;
                default:                w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_start  = (r_state == ST_IDLE) & MAR_load & ~PC_en;
        w_commit = (r_state == ST_FULL) & IR_load & ~PC_en;
    end

    // inc_done allows exactly one PC step per accepted MAR_load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_mar      <= '0;
            r_buf      <= '0;
            r_cw       <= '0;
            r_rdy      <= 1'b0;
            r_inc_done <= 1'b1;
        end else begin
            if (w_byte_vld)
                r_buf[W_CW-1-DATA_W*int'(w_slot) -: DATA_W] <= mem_rdata;
            if (PC_en) begin
                r_pc       <= PC_load;
                r_inc_done <= 1'b1;
                r_rdy      <= 1'b0;
            end else begin
                if (PC_inc && !r_inc_done) begin
                    r_pc       <= r_pc + DATA_W'(INSTR_BYTES);
                    r_inc_done <= 1'b1;
                end
                if (w_start) begin
                    r_mar      <= r_pc;
                    r_inc_done <= 1'b0;
                    r_rdy      <= 1'b0;
                end
                if (w_commit) begin
                    r_cw  <= r_buf;
                    r_rdy <= 1'b1;
                end
            end
        end
    end

    assign mem_req      = w_mem_req;
    assign command_word = r_cw;
    assign ReadyRegFlag = r_rdy;
    assign pc_out       = r_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory model checks
// request addresses, a monitor checks committed instructions.
module tb_instr_fetch_unit;

    typedef struct {
        logic [23:0] cw;
        logic [7:0]  pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  PC_load = 8'h00;
    logic        PC_en = 1'b0;
    logic        PC_inc = 1'b0;
    logic        MAR_load = 1'b0;
    logic        IR_load = 1'b0;
    logic [7:0]  mem_addr;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [23:0] command_word;
    logic        ReadyRegFlag;
    logic [7:0]  pc_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [256];
    exp_t        exp_q[$];
    logic [7:0]  addr_q[$];
    int          fixed_wait = 0;
    bit          rand_wait = 1'b0;
    int          max_wait = 3;
    int          ack_cnt = 0;
    int          mw = -1;
    logic [7:0]  m_pc = 8'h00;
    logic [23:0] last_cw = 24'h0;

    logic        p_req = 1'b0;
    logic        p_ack = 1'b0;
    logic        p_rst = 1'b0;
    logic        p_rdy = 1'b0;
    logic [7:0]  p_addr = 8'h00;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .PC_load      (PC_load),
        .PC_en        (PC_en),
        .PC_inc       (PC_inc),
        .MAR_load     (MAR_load),
        .IR_load      (IR_load),
        .mem_addr     (mem_addr),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .command_word (command_word),
        .ReadyRegFlag (ReadyRegFlag),
        .pc_out       (pc_out)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Memory: waits a number of cycles per byte, then pulses ack.
    initial begin
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                if (mw < 0)
                    mw = rand_wait ? int'($urandom_range(0, max_wait)) : fixed_wait;
                if (mw == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    ack_cnt++;
                    if (addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_read actual=%h required=none", mem_addr);
                    end else begin
                        check("read_addr", mem_addr, addr_q.pop_front());
                    end
                    mw = -1;
                end else begin
                    mw--;
                end
            end else begin
                mw = -1;
            end
        end
    end

    // Monitor: handshake rules and committed instructions.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (p_req && !p_ack && p_rst) begin
                check("req_hold", mem_req, 1);
                check("addr_stable", mem_addr, p_addr);
            end
            if (ReadyRegFlag && !p_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit actual=%h required=none", command_word);
                end else begin
                    e = exp_q.pop_front();
                    check("commit_cw", command_word, e.cw);
                    check("commit_pc", pc_out, e.pc);
                end
            end
            p_req  = mem_req;
            p_ack  = mem_ack;
            p_rst  = rst;
            p_rdy  = ReadyRegFlag;
            p_addr = mem_addr;
        end
    end

    task automatic set_pc(input logic [7:0] t);
        PC_load = t;
        PC_en   = 1'b1;
        @(negedge clk);
        PC_en = 1'b0;
        m_pc  = t;
    endtask

    // Mimics the ControlUnit FETCH_0..2 retry loop until the IR is ready.
    task automatic do_fetch(input bit use_inc);
        exp_t       e;
        logic [7:0] a1;
        logic [7:0] a2;
        int         ph;
        int         guard;
        a1 = m_pc + 8'd1;
        a2 = m_pc + 8'd2;
        addr_q.push_back(m_pc);
        addr_q.push_back(a1);
        addr_q.push_back(a2);
        e.cw = {mem[m_pc], mem[a1], mem[a2]};
        e.pc = use_inc ? m_pc + 8'd3 : m_pc;
        exp_q.push_back(e);
        MAR_load = 1'b1;
        @(negedge clk);
        MAR_load = 1'b0;
        ph = 1;
        guard = 0;
        while (ReadyRegFlag !== 1'b1 && guard < 200) begin
            MAR_load = (ph == 0);
            PC_inc   = use_inc && (ph == 1);
            IR_load  = (ph == 2);
            @(negedge clk);
            ph = (ph + 1) % 3;
            guard++;
        end
        MAR_load = 1'b0;
        PC_inc   = 1'b0;
        IR_load  = 1'b0;
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL fetch_timeout actual=%0d required=<200", guard);
        end
        last_cw = e.cw;
        m_pc    = e.pc;
    endtask

    initial begin
        int start_acks;
        int g;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        repeat (2) @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_cw", command_word, 0);
        check("rst_rdy", ReadyRegFlag, 0);
        check("rst_pc", pc_out, 8'h00);
        rst = 1'b1;
        @(negedge clk);

        // Zero-wait fetch of 03 01 02.
        mem[0] = 8'h03;
        mem[1] = 8'h01;
        mem[2] = 8'h02;
        fixed_wait = 0;
        m_pc = 8'h00;
        do_fetch(1'b1);
        check("t1_cw", command_word, 24'h030102);
        check("t1_rdy", ReadyRegFlag, 1);
        check("t1_pc", pc_out, 8'h03);
        PC_inc = 1'b1;
        @(negedge clk);
        PC_inc = 1'b0;
        check("t1_extra_inc", pc_out, 8'h03);

        // Slow memory with retry loop: still one increment.
        set_pc(8'h00);
        fixed_wait = 4;
        do_fetch(1'b1);
        check("t2_pc", pc_out, 8'h03);
        check("t2_cw", command_word, 24'h030102);

        // Address wrap.
        set_pc(8'hFE);
        fixed_wait = 0;
        do_fetch(1'b1);
        check("t3_pc", pc_out, 8'h01);

        // Jump while byte 1 is pending.
        set_pc(8'h10);
        fixed_wait = 4;
        addr_q.push_back(8'h10);
        addr_q.push_back(8'h11);
        start_acks = ack_cnt;
        MAR_load = 1'b1;
        @(negedge clk);
        MAR_load = 1'b0;
        g = 0;
        while (ack_cnt == start_acks && g < 50) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(negedge clk);
        PC_load = 8'h40;
        PC_en   = 1'b1;
        @(negedge clk);
        PC_en = 1'b0;
        m_pc  = 8'h40;
        check("t4_rdy", ReadyRegFlag, 0);
        check("t4_req_held", mem_req, 1);
        g = 0;
        while (mem_req === 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("t4_drain", mem_req, 0);
        check("t4_acks", ack_cnt - start_acks, 2);
        check("t4_cw_kept", command_word, last_cw);
        check("t4_pc", pc_out, 8'h40);
        fixed_wait = 0;
        do_fetch(1'b1);
        check("t4_pc_after", pc_out, 8'h43);

        // Reset in the middle of a fetch.
        fixed_wait = 6;
        MAR_load = 1'b1;
        @(negedge clk);
        MAR_load = 1'b0;
        @(negedge clk);
        check("t5_req_on", mem_req, 1);
        rst = 1'b0;
        @(negedge clk);
        check("t5_req", mem_req, 0);
        check("t5_pc", pc_out, 8'h00);
        check("t5_cw", command_word, 0);
        check("t5_rdy", ReadyRegFlag, 0);
        rst = 1'b1;
        m_pc = 8'h00;
        @(negedge clk);

        // Jump, increment and fetch start in one cycle.
        fixed_wait = 0;
        do_fetch(1'b0);
        PC_load  = 8'h80;
        PC_en    = 1'b1;
        PC_inc   = 1'b1;
        MAR_load = 1'b1;
        @(negedge clk);
        PC_en    = 1'b0;
        PC_inc   = 1'b0;
        MAR_load = 1'b0;
        m_pc     = 8'h80;
        check("t6_pc", pc_out, 8'h80);
        check("t6_rdy", ReadyRegFlag, 0);
        @(negedge clk);
        check("t6_no_fetch", mem_req, 0);
        PC_inc = 1'b1;
        @(negedge clk);
        PC_inc = 1'b0;
        check("t6_no_inc", pc_out, 8'h80);

        // Random traffic.
        rand_wait = 1'b1;
        max_wait  = 3;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) set_pc(8'($urandom));
            do_fetch(1'($urandom_range(0, 1)));
            check("rnd_pc", pc_out, m_pc);
        end

        repeat (4) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("addr_q_empty", addr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of ControlUnit. Owns the PC, the MAR, a byte-wide instruction-memory read handshake, a 3-byte assembly buffer and the IR.
- Obeys the ControlUnit strobes PC_load/PC_en/PC_inc/MAR_load/IR_load.
- Produces command_word (opcode[23:16], op1[15:8], op2[7:0]) and ReadyRegFlag.

Parameters:
- DATA_W, 8, width of PC, MAR, memory address and data.
- INSTR_BYTES, 3, bytes per instruction; the PC step size.
- RESET_PC, 8'h00, PC value after reset.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-low reset.
- PC_load  in  8  jump target.
- PC_en  in  1  load PC from PC_load.
- PC_inc  in  1  advance PC by INSTR_BYTES.
- MAR_load  in  1  start a fetch at the current PC.
- IR_load  in  1  commit the assembled instruction to the IR.
- mem_addr  out  8  instruction-memory byte address.
- mem_req  out  1  read request; held until mem_ack.
- mem_ack  in  1  read data valid; single-cycle pulse.
- mem_rdata  in  8  read data, sampled when mem_ack=1.
- command_word  out  24  IR contents.
- ReadyRegFlag  out  1  IR holds a complete, current instruction.
- pc_out  out  8  current PC (for CALL/RET).

Behaviour:
- Reset (rst=0 at posedge):
  - PC=RESET_PC, MAR=0, command_word=0, ReadyRegFlag=0, mem_req=0, mem_addr=0.
  - Byte counter=0, inc_done=1, FSM=IDLE.
  - An in-flight request is dropped immediately.
- FSM states: IDLE, FETCH, FULL, FLUSH.
- IDLE:
  - MAR_load → MAR=PC, cnt=0, inc_done=0, ReadyRegFlag=0, go to FETCH.
- FETCH:
  - mem_req=1, mem_addr=MAR+cnt (mod 256).
  - On mem_ack the byte goes into buffer slot cnt. Slot 0→[23:16], 1→[15:8], 2→[7:0].
  - cnt increments. mem_addr updates the next cycle; mem_req may stay high between bytes.
  - After byte INSTR_BYTES-1 is acked: mem_req=0, go to FULL.
  - Latency MAR_load→FULL is 3+Σ(ack waits) cycles; minimum 3 with zero-wait memory.
- FULL:
  - IR_load → command_word=buffer and ReadyRegFlag=1 on the next edge, go to IDLE.
- IR_load in IDLE or FETCH: ignored; ReadyRegFlag stays 0. ControlUnit retries through FETCH_0.
- MAR_load in FETCH or FULL: ignored. A fetch is never restarted or duplicated.
- PC_inc:
  - Honoured only when inc_done=0: PC=PC+3 mod 256 (wraps, e.g. 8'hFE→8'h01), then inc_done=1.
  - Otherwise ignored. This gives exactly one increment per accepted MAR_load, so the ControlUnit retry loop is safe.
- PC_en (any state):
  - PC=PC_load, ReadyRegFlag=0, inc_done=1.
  - Buffer is discarded. In FETCH with mem_req high: go to FLUSH, keep mem_req until mem_ack, discard the data, then go to IDLE. Otherwise go to IDLE.
- Priority within a cycle: rst > PC_en > PC_inc. PC_en with MAR_load: MAR_load ignored. PC_en with IR_load: IR not updated.
- mem_req must not drop before mem_ack except on reset. mem_addr is stable while mem_req=1 and no ack has been seen.
- ReadyRegFlag is registered and cleared only by reset, an accepted MAR_load, or PC_en.
- command_word holds its value until the next accepted IR_load.

Decomposition:
- Shared package/header cpu_defs:
  - Opcode localparams, shared with ControlUnit.
  - INSTR_BYTES and field slice positions: OPC [23:16], OP1 [15:8], OP2 [7:0].
  - Fetch FSM state encoding.
- One natural sub-module, fetch_mem_if: the req/ack handshake, byte counter and FLUSH drain, returning a byte-valid pulse and slot index.
- PC/MAR/IR registers and strobe arbitration stay in the top module.

Test Plan:
- Zero-wait memory, mem[0..2]=8'h03,8'h01,8'h02; strobes MAR_load, PC_inc, IR_load repeated → command_word=24'h030102, ReadyRegFlag=1, PC=8'h03, exactly one +3 increment.
- mem_ack delayed 4 cycles per byte with the ControlUnit looping FETCH_0..2 → no duplicate requests, PC=3 (not 6/9), command_word correct once FULL.
- PC=8'hFE, fetch → bytes read from 8'hFE, 8'hFF, 8'h00; after PC_inc, PC=8'h01.
- PC_en with PC_load=8'h40 while byte 1 is pending → mem_req held until ack, data discarded, ReadyRegFlag=0, next fetch reads from 8'h40.
- rst=0 asserted mid-FETCH with mem_req=1 → next cycle mem_req=0, PC=RESET_PC, command_word=0, ReadyRegFlag=0.
- PC_en, PC_inc and MAR_load in the same cycle → PC=PC_load, no fetch started, no increment.
